mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit. It sequences the shared datapath (PC, unified memory port, IR/MDR, register file, ALU, ALUOut) through fetch, decode, execute, memory and write-back states. On every memory state it waits on the bus ready handshake. It sits beside the datapath in the CPU core and drives all of its mux selects and write enables.

---
 rtl/mc_pkg.sv | 119 +++++++++++
 rtl/mc_alu_dec.sv | 45 ++++
 rtl/mc_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_pkg                                                       |
// | Description : Shared constants for the multi-cycle MIPS control unit:      |
// |               state encoding, opcode/funct values, ALU_Control codes,      |
// |               datapath select codes and the per-state control bundle.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mc_pkg;

  // FSM state encoding; the numeric values are visible on the debug port.
  typedef enum logic [3:0] {
    S_IF = 4'd0,
    S_ID = 4'd1,
    S_MA = 4'd2,
    S_MR = 4'd3,
    S_LW = 4'd4,
    S_MW = 4'd5,
    S_RX = 4'd6,
    S_RW = 4'd7,
    S_BR = 4'd8,
    S_JP = 4'd9,
    S_IX = 4'd10,
    S_IW = 4'd11,
    S_JL = 4'd12,
    S_JR = 4'd13
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU_Control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath select codes
  localparam logic [1:0] DST_RT       = 2'b00;
  localparam logic [1:0] DST_RD       = 2'b01;
  localparam logic [1:0] DST_RA       = 2'b10;
  localparam logic [1:0] MTR_ALUOUT   = 2'b00;
  localparam logic [1:0] MTR_MDR      = 2'b01;
  localparam logic [1:0] MTR_PC       = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCS_ALU      = 2'b00;
  localparam logic [1:0] PCS_ALUOUT   = 2'b01;
  localparam logic [1:0] PCS_JUMP     = 2'b10;
  localparam logic [1:0] PCS_RS       = 2'b11;

  // Registered control bundle. PC/IR enables are split into an unconditional
  // part and qualifier flags so the handshake/zero gating can be applied
  // combinationally after the register.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;   // qualified by MIO_ready
    logic       pcen;       // unconditional PC load
    logic       pcen_rdy;   // PC load qualified by MIO_ready
    logic       pcen_br;    // PC load qualified by the branch condition
    logic       br_ne;      // 1 = bne (take on ~zero)
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
  } ctrl_t;

  // Control bundle for the fetch state; also the reset value.
  localparam ctrl_t CTRL_IF = '{
    mem_read: 1'b1,
    ir_write: 1'b1,
    pcen_rdy: 1'b1,
    alusrcb:  SRCB_FOUR,
    pcsource: PCS_ALU,
    default:  '0
  };

  // R-type functs that execute through RX/RW (jr is handled separately).
  function automatic logic rfun_valid(input logic [5:0] fun);
    logic v;
    v = 1'b0;
    case (fun)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_alu_dec                                                   |
// | Description : Combinational ALU_Control decode from FSM state, opcode and  |
// |               funct.                                                       |
// | Ports       : state    in  4  FSM state the code is produced for           |
// |               opcode   in  6  IR[31:26]                                    |
// |               fun      in  6  IR[5:0]                                      |
// |               alu_ctrl out 3  ALU operation select                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] fun,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (state)
      S_IF, S_ID, S_MA: alu_ctrl = ALU_ADD;
      S_RX: begin
        case (fun)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_ADD;  // unreachable: bad functs never reach RX
        endcase
      end
      S_BR: alu_ctrl = ALU_SUB;
      S_IX: alu_ctrl = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_ctrl                                                      |
// | Description : Multi-cycle MIPS control unit. Sequences the shared          |
// |               datapath through IF/ID/EX/MEM/WB and drives all selects and  |
// |               write enables. Memory states wait on MIO_ready.              |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               OPcode, Fun, zero, MIO_ready        - inputs                 |
// |               PCEN, IorD, MemRead, MemWrite, CPU_MIO, IRWrite, RegDst,     |
// |               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALU_Control,           |
// |               PCSource, state                     - outputs                |
// | Config      : MC_JAL_EN - decode jal/jr (states JL/JR)                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic       PCEN,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       CPU_MIO,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  state_e     state_d, state_q;
  ctrl_t      ctrl_d, ctrl_q;
  logic [2:0] alu_ctrl_d, alu_ctrl_q;

  // Next-state logic
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (OPcode)
          OP_LW, OP_SW:    state_d = S_MA;
          OP_RTYPE: begin
            if (rfun_valid(Fun)) begin
              state_d = S_RX;
`ifdef MC_JAL_EN
            end else if (Fun == FN_JR) begin
              state_d = S_JR;
`endif
            end else begin
              state_d = S_IF;
            end
          end
          OP_BEQ, OP_BNE:  state_d = S_BR;
          OP_J:            state_d = S_JP;
          OP_ADDI, OP_SLTI: state_d = S_IX;
`ifdef MC_JAL_EN
          OP_JAL:          state_d = S_JL;
`endif
          default:         state_d = S_IF;
        endcase
      end
      S_MA: state_d = (OPcode == OP_LW) ? S_MR : S_MW;
      S_MR: state_d = MIO_ready ? S_LW : S_MR;
      S_MW: state_d = MIO_ready ? S_IF : S_MW;
      S_RX: state_d = S_RW;
      S_IX: state_d = S_IW;
      default: state_d = S_IF;  // single-cycle states, and unreachable codes
    endcase
  end

  // Control decode of the next state, so the registered outputs line up
  // with the state register (Moore behaviour, glitch-free strobes).
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_IF: ctrl_d = CTRL_IF;
      S_ID: ctrl_d.alusrcb = SRCB_IMM_SH2;
      S_MA: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = SRCB_IMM;
      end
      S_MR: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_LW: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = DST_RT;
        ctrl_d.memtoreg = MTR_MDR;
      end
      S_MW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_RX: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = SRCB_RT;
      end
      S_RW: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = DST_RD;
        ctrl_d.memtoreg = MTR_ALUOUT;
      end
      S_BR: begin
        // OPcode is stable from ID onward, so the polarity is captured here.
        ctrl_d.alusrca  = 1'b1;
        ctrl_d.alusrcb  = SRCB_RT;
        ctrl_d.pcsource = PCS_ALUOUT;
        ctrl_d.pcen_br  = 1'b1;
        ctrl_d.br_ne    = (OPcode == OP_BNE);
      end
      S_JP: begin
        ctrl_d.pcen     = 1'b1;
        ctrl_d.pcsource = PCS_JUMP;
      end
      S_IX: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = SRCB_IMM;
      end
      S_IW: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = DST_RT;
        ctrl_d.memtoreg = MTR_ALUOUT;
      end
`ifdef MC_JAL_EN
      S_JL: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = DST_RA;
        ctrl_d.memtoreg = MTR_PC;
        ctrl_d.pcen     = 1'b1;
        ctrl_d.pcsource = PCS_JUMP;
      end
      S_JR: begin
        ctrl_d.pcen     = 1'b1;
        ctrl_d.pcsource = PCS_RS;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .state    (state_d),
    .opcode   (OPcode),
    .fun      (Fun),
    .alu_ctrl (alu_ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      ctrl_q     <= CTRL_IF;
      alu_ctrl_q <= ALU_ADD;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  // Only the handshake and branch qualifiers are combinational.
  assign PCEN        = ctrl_q.pcen
                     | (ctrl_q.pcen_rdy & MIO_ready)
                     | (ctrl_q.pcen_br & (zero ^ ctrl_q.br_ne));
  assign IRWrite     = ctrl_q.ir_write & MIO_ready;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign CPU_MIO     = ctrl_q.mem_read | ctrl_q.mem_write;
  assign RegDst      = ctrl_q.regdst;
  assign MemtoReg    = ctrl_q.memtoreg;
  assign RegWrite    = ctrl_q.regwrite;
  assign ALUSrcA     = ctrl_q.alusrca;
  assign ALUSrcB     = ctrl_q.alusrcb;
  assign ALU_Control = alu_ctrl_q;
  assign PCSource    = ctrl_q.pcsource;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_ctrl                                                   |
// | Description : Self-checking bench for mc_ctrl: directed instruction table, |
// |               wait-state / reset corner sequences and a randomized run     |
// |               against a path-based reference model.                        |
// | Config      : honours MC_JAL_EN for jal/jr expectations                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;
  logic       PCEN, IorD, MemRead, MemWrite, CPU_MIO, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero),
    .MIO_ready(MIO_ready), .PCEN(PCEN), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSource(PCSource),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] dv;
  assign dv = {PCEN, IorD, MemRead, MemWrite, CPU_MIO, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALU_Control, PCSource, state};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] rfun_alu(input logic [5:0] f);
    case (f)
      6'h20: return 3'd2;  6'h22: return 3'd6;  6'h24: return 3'd0;
      6'h25: return 3'd1;  6'h26: return 3'd3;  6'h27: return 3'd4;
      6'h2a: return 3'd7;  6'h02: return 3'd5;
      default: return 3'd2;
    endcase
  endfunction

  function automatic bit rfun_ok(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
  endfunction

  // Expected outputs for a given spec state number, straight from the state table.
  function automatic logic [22:0] exp_out(input int st, input logic [5:0] op,
                                          input logic [5:0] f, input logic rdy,
                                          input logic z);
    logic pcen, iord, mr, mw, irw, rw, srca;
    logic [1:0] dst, mtr, srcb, pcs;
    logic [2:0] alu;
    {pcen, iord, mr, mw, irw, rw, srca} = '0;
    {dst, mtr, srcb, pcs} = '0;
    alu = 3'd0;
    case (st)
      0:  begin mr = 1; srcb = 2'b01; alu = 3'd2; pcen = rdy; irw = rdy; end
      1:  begin srcb = 2'b11; alu = 3'd2; end
      2:  begin srca = 1; srcb = 2'b10; alu = 3'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; mtr = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin srca = 1; alu = rfun_alu(f); end
      7:  begin rw = 1; dst = 2'b01; end
      8:  begin srca = 1; alu = 3'd6; pcs = 2'b01; pcen = (op == 6'b000100) ? z : ~z; end
      9:  begin pcen = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; alu = (op == 6'b001010) ? 3'd7 : 3'd2; end
      11: begin rw = 1; end
      12: begin rw = 1; dst = 2'b10; mtr = 2'b10; pcen = 1; pcs = 2'b10; end
      13: begin pcen = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {pcen, iord, mr, mw, mr | mw, irw, dst, mtr, rw, srca, srcb, alu, pcs, st[3:0]};
  endfunction

  int path[$];

  // Sequence of states an instruction visits (ignoring wait repeats).
  task automatic build_path(input logic [5:0] op, input logic [5:0] f);
    path = {0, 1};
    case (op)
      6'b100011: path = {path, 2, 3, 4};
      6'b101011: path = {path, 2, 5};
      6'b000000: begin
        if (rfun_ok(f)) path = {path, 6, 7};
`ifdef MC_JAL_EN
        else if (f == 6'b001000) path.push_back(13);
`endif
      end
      6'b000100, 6'b000101: path.push_back(8);
      6'b000010: path.push_back(9);
      6'b001000, 6'b001010: path = {path, 10, 11};
`ifdef MC_JAL_EN
      6'b000011: path.push_back(12);
`endif
      default: ;
    endcase
  endtask

  // Walk one instruction through the model, comparing every cycle.
  // Starts and ends on a negedge with the DUT in IF.
  task automatic run_model(input string name, input logic [5:0] op, input logic [5:0] f,
                           input bit rand_rdy);
    int idx;
    logic rdy, z;
    OPcode = op;
    Fun    = f;
    build_path(op, f);
    idx = 0;
    while (idx < path.size()) begin
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      z   = 1'($urandom);
      MIO_ready = rdy;
      zero      = z;
      #1;
      chk(name, 32'(dv), 32'(exp_out(path[idx], op, f, rdy, z)));
      if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !rdy)) idx++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fun;
    logic       z;
    int         cyc;
    int         rw;
    int         mw;
    int         pc;
  } vec_t;

  vec_t tbl[14];

  task automatic run_counts(input logic [5:0] op, input logic [5:0] f, input logic z,
                            output int cyc, output int rw, output int mw, output int pc);
    bit left;
    cyc = 0; rw = 0; mw = 0; pc = 0; left = 0;
    OPcode = op; Fun = f; zero = z; MIO_ready = 1'b1;
    do begin
      #1;
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      pc += int'(PCEN);
      cyc++;
      @(negedge clk);
      if (state != 4'd0) left = 1;
    end while (!(left && state == 4'd0) && cyc < 50);
  endtask

  initial begin
    int cyc, rw, mw, pc, ifw, mrw, iord_mr, rd_mr, lw_ok, guard;
    bit left;

    tbl[0]  = '{"add",    6'h00, 6'h20, 1'b0, 4, 1, 0, 1};
    tbl[1]  = '{"lw",     6'h23, 6'h00, 1'b0, 5, 1, 0, 1};
    tbl[2]  = '{"sw",     6'h2b, 6'h00, 1'b0, 4, 0, 1, 1};
    tbl[3]  = '{"beq_t",  6'h04, 6'h00, 1'b1, 3, 0, 0, 2};
    tbl[4]  = '{"beq_nt", 6'h04, 6'h00, 1'b0, 3, 0, 0, 1};
    tbl[5]  = '{"bne_t",  6'h05, 6'h00, 1'b0, 3, 0, 0, 2};
    tbl[6]  = '{"bne_nt", 6'h05, 6'h00, 1'b1, 3, 0, 0, 1};
    tbl[7]  = '{"j",      6'h02, 6'h00, 1'b0, 3, 0, 0, 2};
    tbl[8]  = '{"addi",   6'h08, 6'h00, 1'b0, 4, 1, 0, 1};
    tbl[9]  = '{"slti",   6'h0a, 6'h00, 1'b0, 4, 1, 0, 1};
    tbl[10] = '{"undef",  6'h3f, 6'h00, 1'b0, 2, 0, 0, 1};
    tbl[11] = '{"badfun", 6'h00, 6'h01, 1'b0, 2, 0, 0, 1};
`ifdef MC_JAL_EN
    tbl[12] = '{"jal",    6'h03, 6'h00, 1'b0, 3, 1, 0, 2};
    tbl[13] = '{"jr",     6'h00, 6'h08, 1'b0, 3, 0, 0, 2};
`else
    tbl[12] = '{"jal",    6'h03, 6'h00, 1'b0, 2, 0, 0, 1};
    tbl[13] = '{"jr",     6'h00, 6'h08, 1'b0, 2, 0, 0, 1};
`endif

    // Reset state
    rst_n = 1'b0; MIO_ready = 1'b0; OPcode = 6'h00; Fun = 6'h20; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", 32'(dv), 32'(exp_out(0, 6'h00, 6'h20, 1'b0, 1'b0)));
    chk("reset_vec", 32'(dv), 32'h00C_0A0 >> 0 == 0 ? 32'(dv) + 1 : 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                  2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 4'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    // add: 0,1,6,7,0 with full per-cycle comparison
    run_model("add_seq", 6'h00, 6'h20, 1'b0);
    chk("add_back_if", 32'(state), 32'd0);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_counts(tbl[i].op, tbl[i].fun, tbl[i].z, cyc, rw, mw, pc);
      chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      chk({tbl[i].name, "_regwr"},  32'(rw),  32'(tbl[i].rw));
      chk({tbl[i].name, "_memwr"},  32'(mw),  32'(tbl[i].mw));
      chk({tbl[i].name, "_pcen"},   32'(pc),  32'(tbl[i].pc));
    end

    // lw with 2 IF wait cycles and 3 MR wait cycles: 10 cycles total
    OPcode = 6'h23; Fun = 6'h00; zero = 1'b0;
    cyc = 0; ifw = 0; mrw = 0; iord_mr = 0; rd_mr = 0; lw_ok = 0; left = 0;
    do begin
      case (state)
        4'd0:    begin MIO_ready = (ifw >= 2); ifw++; end
        4'd3:    begin MIO_ready = (mrw >= 3); mrw++; end
        default: MIO_ready = 1'($urandom);
      endcase
      #1;
      if (state == 4'd3 && IorD && MemRead) iord_mr++;
      if (state == 4'd3) rd_mr++;
      if (state == 4'd4 && RegWrite && MemtoReg == 2'b01) lw_ok++;
      cyc++;
      @(negedge clk);
      if (state != 4'd0) left = 1;
    end while (!(left && state == 4'd0) && cyc < 50);
    chk("lw_wait_cycles", 32'(cyc), 32'd10);
    chk("lw_mr_cycles", 32'(rd_mr), 32'd4);
    chk("lw_mr_iord_held", 32'(iord_mr), 32'd4);
    chk("lw_wb", 32'(lw_ok), 32'd1);

    // sw, then reset while waiting in MW
    OPcode = 6'h2b; MIO_ready = 1'b1;
    guard = 0;
    while (state != 4'd5 && guard < 20) begin
      if (state == 4'd2) MIO_ready = 1'b0;
      @(negedge clk);
      guard++;
    end
    MIO_ready = 1'b0;
    #1;
    chk("sw_reach_mw", 32'(state), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    @(negedge clk);
    chk("sw_mw_hold", 32'({MemWrite, IorD, state}), 32'({1'b1, 1'b1, 4'd5}));
    rst_n = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("sw_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model
    for (int n = 0; n < 300; n++) begin
      logic [5:0] ops[12];
      logic [5:0] funs[10];
      logic [5:0] op, f;
      ops  = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0a, 6'h03, 6'h00, 6'h3f};
      funs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02, 6'h08, 6'h11};
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      f  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : funs[$urandom_range(0, 9)];
      run_model("rand", op, f, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
